truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/ttc_pkg.sv | 15 +
 rtl/minority_ref.sv | 11 +
 rtl/truth_table_checker.sv | 143 ++++++++++++++
 tb/tb_truth_table_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// Shared types and constants for the truth-table checker.
package ttc_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = $clog2(NUM_VECTORS);
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/minority_ref.sv
// Golden model: expected response is 1 when fewer than two stimulus bits are set.
module minority_ref
    import ttc_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             expected
);

    assign expected = ~((vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]));

endmodule

// File: rtl/truth_table_checker.sv
// Walks all 3-bit vectors, compares y with the minority function and records errors.
// Optional macro TRUTH_TABLE_CHECKER_MASK_EN adds the per-vector err_mask output.
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   y,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [3:0]             err_count,
    output logic [2:0]             first_fail
`ifdef TRUTH_TABLE_CHECKER_MASK_EN
    ,
    output logic [NUM_VECTORS-1:0] err_mask
`endif
);

    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [VEC_W-1:0]  vec_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [3:0]        err_count_reg;
    logic [2:0]        first_fail_reg;
    logic              expected;
    logic              mismatch;
    logic              accept;

    minority_ref u_ref (
        .vec      (vec_reg),
        .expected (expected)
    );

    // Only meaningful while state_reg is SAMPLE; gated at every use.
    assign mismatch = (y != expected);
    assign accept   = (state_reg == IDLE) && start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (cnt_reg == SETTLE_END) state_next = SAMPLE;
            SAMPLE:  state_next = (vec_reg == LAST_VEC) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_reg)
            SETTLE,
            SAMPLE:  busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_reg        <= '0;
            cnt_reg        <= '0;
            err_count_reg  <= '0;
            first_fail_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        vec_reg        <= '0;
                        cnt_reg        <= '0;
                        err_count_reg  <= '0;
                        first_fail_reg <= '0;
                    end
                end
                SETTLE: cnt_reg <= cnt_reg + 1'b1;
                SAMPLE: begin
                    if (mismatch) begin
                        err_count_reg <= err_count_reg + 1'b1;
                        if (err_count_reg == '0) begin
                            first_fail_reg <= vec_reg;
                        end
                    end
                    // Stop on the last vector so a/b/c rest at 111 afterwards.
                    if (vec_reg != LAST_VEC) begin
                        vec_reg <= vec_reg + 1'b1;
                        cnt_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRUTH_TABLE_CHECKER_MASK_EN
    logic [NUM_VECTORS-1:0] err_mask_reg;

    generate
        for (genvar gi = 0; gi < NUM_VECTORS; gi++) begin : g_mask
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    err_mask_reg[gi] <= 1'b0;
                end else if (accept) begin
                    err_mask_reg[gi] <= 1'b0;
                end else if ((state_reg == SAMPLE) && mismatch && (vec_reg == VEC_W'(gi))) begin
                    err_mask_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign err_mask = err_mask_reg;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign a          = vec_reg[2];
    assign b          = vec_reg[1];
    assign c          = vec_reg[0];
    assign err_count  = err_count_reg;
    assign first_fail = first_fail_reg;
    assign pass       = (err_count_reg == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: table of y-response patterns plus
// hand sequences for re-pulsed start, mid-run reset and SETTLE_CYCLES=3.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, start3;
    logic       y, y3;
    logic       a, b, c, busy, done, pass;
    logic       a3, b3, c3, busy3, done3, pass3;
    logic [3:0] err_count, err_count3;
    logic [2:0] first_fail, first_fail3;
`ifdef TRUTH_TABLE_CHECKER_MASK_EN
    logic [7:0] err_mask, err_mask3;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   mode     = 0;
    logic inv      = 1'b0;
    logic m_ref;

    always #5 clk = ~clk;

    truth_table_checker #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .y(y),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail)
`ifdef TRUTH_TABLE_CHECKER_MASK_EN
        , .err_mask(err_mask)
`endif
    );

    truth_table_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .y(y3),
        .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .first_fail(first_fail3)
`ifdef TRUTH_TABLE_CHECKER_MASK_EN
        , .err_mask(err_mask3)
`endif
    );

    function automatic logic minority3(input logic [2:0] v);
        return (int'(v[0]) + int'(v[1]) + int'(v[2])) < 2;
    endfunction

    assign m_ref = minority3({a, b, c});
    assign y3    = minority3({a3, b3, c3});

    always_comb begin
        y = m_ref;
        case (mode)
            1:       y = 1'b0;
            2:       y = ~m_ref;
            3:       y = 1'b1;
            4:       y = a;
            5:       y = ~c;
            6:       y = m_ref ^ inv;
            default: y = m_ref;
        endcase
    end

    typedef struct {
        string name;
        int    mode;
        int    err;
        int    first;
        int    pass;
        int    mask;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run on the default instance, checking latency, stimulus order and results.
    task automatic run_table(input vec_t t);
        int lat = 0;
        int vec_bad = 0;
        int busy_bad = 0;
        mode  = t.mode;
        inv   = 1'b1;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (int'({a, b, c}) != (n - 1) / 2) vec_bad++;
            if (busy !== 1'b1) busy_bad++;
            inv = (n % 2 == 1);
        end
        inv = 1'b0;
        check({t.name, "_latency"}, lat, 17);
        check({t.name, "_vec_order_errs"}, vec_bad, 0);
        check({t.name, "_busy_errs"}, busy_bad, 0);
        check({t.name, "_err_count"}, int'(err_count), t.err);
        check({t.name, "_first_fail"}, int'(first_fail), t.first);
        check({t.name, "_pass"}, int'(pass), t.pass);
        check({t.name, "_abc_end"}, int'({a, b, c}), 7);
        check({t.name, "_busy_in_done"}, int'(busy), 0);
`ifdef TRUTH_TABLE_CHECKER_MASK_EN
        check({t.name, "_err_mask"}, int'(err_mask), t.mask);
`endif
        tick();
        check({t.name, "_done_one_cycle"}, int'(done), 0);
        tick();
        tick();
        check({t.name, "_hold_err_count"}, int'(err_count), t.err);
        check({t.name, "_hold_abc"}, int'({a, b, c}), 7);
        $display("run %s: latency=%0d err_count=%0d first_fail=%0d pass=%0d",
                 t.name, lat, err_count, first_fail, pass);
    endtask

    initial begin
        int lat, lat2, done_cnt, bad;

        tbl[0] = '{"correct",       0, 0, 0, 1, 'h00};
        tbl[1] = '{"stuck0",        1, 4, 0, 0, 'h17};
        tbl[2] = '{"majority",      2, 8, 0, 0, 'hFF};
        tbl[3] = '{"stuck1",        3, 4, 3, 0, 'hE8};
        tbl[4] = '{"y_eq_a",        4, 6, 0, 0, 'hE7};
        tbl[5] = '{"y_not_c",       5, 2, 1, 0, 'h42};
        tbl[6] = '{"settle_glitch", 6, 0, 0, 1, 'h00};

        reset_n = 1'b0;
        start   = 1'b0;
        start3  = 1'b0;
        tick();
        tick();
        check("reset_abc", int'({a, b, c}), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err_count", int'(err_count), 0);
        check("reset_first_fail", int'(first_fail), 0);
        check("reset_pass", int'(pass), 1);
`ifdef TRUTH_TABLE_CHECKER_MASK_EN
        check("reset_err_mask", int'(err_mask), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_table(tbl[i]);
        end

        // start seen mid-run and during the done cycle is dropped; next IDLE start runs.
        mode     = 0;
        lat      = 0;
        lat2     = 0;
        done_cnt = 0;
        start    = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            if (lat > 0 && n == lat + 1) begin
                check("repulse_idle_busy", int'(busy), 0);
                check("repulse_idle_done", int'(done), 0);
            end
            if (lat > 0 && n == lat + 2) begin
                check("repulse_accept_busy", int'(busy), 1);
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat   = n;
                    start = 1'b1;
                end else if (lat2 == 0) begin
                    lat2 = n;
                end
            end
        end
        start = 1'b0;
        check("repulse_first_done", lat, 17);
        check("repulse_second_done", lat2, 35);
        check("repulse_done_count", done_cnt, 2);
        $display("run repulse: first_done=%0d second_done=%0d dones=%0d", lat, lat2, done_cnt);
        tick();

        // Reset mid-run after vector 011 has already failed.
        mode  = 3;
        start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 1) start = 1'b0;
        end
        check("midrun_err_before_reset", int'(err_count), 1);
        reset_n = 1'b0;
        #1;
        check("midrun_reset_abc", int'({a, b, c}), 0);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_err_count", int'(err_count), 0);
        check("midrun_reset_first_fail", int'(first_fail), 0);
        check("midrun_reset_pass", int'(pass), 1);
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done) done_cnt++;
        end
        check("midrun_no_done", done_cnt, 0);
        $display("run midrun_reset: dones_after_reset=%0d", done_cnt);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run_table(tbl[0]);

        // Longer settle: each vector held four cycles.
        lat    = 0;
        bad    = 0;
        start3 = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (n == 1) start3 = 1'b0;
            if (done3) begin
                lat = n;
                break;
            end
            if (int'({a3, b3, c3}) != (n - 1) / 4) bad++;
        end
        check("settle3_latency", lat, 33);
        check("settle3_vec_order_errs", bad, 0);
        check("settle3_pass", int'(pass3), 1);
        check("settle3_err_count", int'(err_count3), 0);
        $display("run settle3: latency=%0d err_count=%0d pass=%0d", lat, err_count3, pass3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
